// File: rtl/hood_mode_controller_pkg.sv
// rtl/hood_mode_controller_pkg.sv - state encodings, default timings and button arbitration for the hood controller
package hood_mode_controller_pkg;

  // Encodings are shared with the power/working indicator decoders.
  typedef enum logic [2:0] {
    ST_OFF         = 3'd0,
    ST_STANDBY     = 3'd1,
    ST_MODE_SELECT = 3'd2,
    ST_FIRST       = 3'd3,
    ST_SECOND      = 3'd4,
    ST_THIRD       = 3'd5,
    ST_SELF_CLEAN  = 3'd6
  } hood_state_e;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_LVL3,
    BTN_LVL2,
    BTN_LVL1,
    BTN_CLEAN,
    BTN_MENU
  } btn_e;

  localparam int DEF_TICK_CYCLES  = 100_000_000;
  localparam int DEF_LONG_PRESS_S = 3;
  localparam int DEF_HURRICANE_S  = 60;
  localparam int DEF_EXIT_S       = 60;
  localparam int DEF_CLEAN_S      = 180;

  // Only the highest-priority pulse is acted on, even if the state then ignores it.
  function automatic btn_e pick_button(input logic lvl3, input logic lvl2, input logic lvl1,
                                       input logic clean, input logic menu);
    btn_e sel;
    if (lvl3)       sel = BTN_LVL3;
    else if (lvl2)  sel = BTN_LVL2;
    else if (lvl1)  sel = BTN_LVL1;
    else if (clean) sel = BTN_CLEAN;
    else if (menu)  sel = BTN_MENU;
    else            sel = BTN_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/hood_mode_controller_sec_ticker.sv
// rtl/hood_mode_controller_sec_ticker.sv - one-second divider with synchronous restart and single-cycle tick
module hood_mode_controller_sec_ticker #(
  parameter int TICK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

  // A restart on a tick cycle wins, so the next tick is a full period away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hood_mode_controller.sv
// rtl/hood_mode_controller.sv - range hood operating-state machine with second timers and long-press power off
module hood_mode_controller
  import hood_mode_controller_pkg::*;
#(
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
  parameter int LONG_PRESS_S = DEF_LONG_PRESS_S,
  parameter int HURRICANE_S  = DEF_HURRICANE_S,
  parameter int EXIT_S       = DEF_EXIT_S,
  parameter int CLEAN_S      = DEF_CLEAN_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       menu_btn,
  input  logic       lvl1_btn,
  input  logic       lvl2_btn,
  input  logic       lvl3_btn,
  input  logic       clean_btn,
  output logic [2:0] state,
  output logic [7:0] countdown,
  output logic       exiting,
  output logic       hurricane_used,
  output logic       clean_done
);

  if (TICK_CYCLES < 1 || LONG_PRESS_S < 1 || HURRICANE_S < 1 || HURRICANE_S > 255 ||
      EXIT_S < 1 || EXIT_S > 255 || CLEAN_S < 1 || CLEAN_S > 255) begin : g_param_check
    $error("hood_mode_controller: timer parameters must lie in 1..255 seconds");
  end

  localparam int LP_CYCLES = LONG_PRESS_S * TICK_CYCLES;
  localparam int LPW       = $clog2(LP_CYCLES + 1);

  hood_state_e    st_q, st_d;
  logic [7:0]     cd_q, cd_d;
  logic           exit_q, exit_d, hu_q, hu_d, done_q, done_d;
  logic           armed_q, armed_d, pwr_q;
  logic [LPW-1:0] lp_q, lp_d;
  logic           load, tick, expire, long_off;
  btn_e           sel;

  hood_mode_controller_sec_ticker #(.TICK_CYCLES(TICK_CYCLES)) u_ticker (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (load),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= ST_OFF;
      cd_q    <= '0;
      exit_q  <= 1'b0;
      hu_q    <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      pwr_q   <= 1'b0;
      lp_q    <= '0;
    end else begin
      st_q    <= st_d;
      cd_q    <= cd_d;
      exit_q  <= exit_d;
      hu_q    <= hu_d;
      done_q  <= done_d;
      armed_q <= armed_d;
      pwr_q   <= power_btn;
      lp_q    <= lp_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    cd_d     = cd_q;
    exit_d   = exit_q;
    hu_d     = hu_q;
    done_d   = 1'b0;
    load     = 1'b0;
    sel      = pick_button(lvl3_btn, lvl2_btn, lvl1_btn, clean_btn, menu_btn);
    expire   = tick && (cd_q == 8'd1);
    long_off = (st_q != ST_OFF) && armed_q && power_btn && (lp_q == LPW'(LP_CYCLES - 1));

    if (st_q == ST_OFF) begin
      if (power_btn && !pwr_q) st_d = ST_STANDBY;
    end else if (long_off) begin
      st_d = ST_OFF;
    end else begin
      case (st_q)
        ST_STANDBY: if (sel == BTN_MENU) st_d = ST_MODE_SELECT;
        ST_MODE_SELECT, ST_FIRST, ST_SECOND: begin
          case (sel)
            BTN_LVL3: if (!hu_q) begin
              st_d = ST_THIRD;
              hu_d = 1'b1;
              cd_d = 8'(HURRICANE_S);
              load = 1'b1;
            end
            BTN_LVL2: st_d = ST_SECOND;
            BTN_LVL1: st_d = ST_FIRST;
            BTN_CLEAN: if (st_q == ST_MODE_SELECT) begin
              st_d = ST_SELF_CLEAN;
              cd_d = 8'(CLEAN_S);
              load = 1'b1;
            end
            BTN_MENU: st_d = ST_STANDBY;
            default: ;
          endcase
        end
        ST_THIRD: begin
          if (expire) begin
            st_d   = exit_q ? ST_STANDBY : ST_SECOND;
            cd_d   = '0;
            exit_d = 1'b0;
          end else if (sel == BTN_MENU && !exit_q) begin
            exit_d = 1'b1;
            cd_d   = 8'(EXIT_S);
            load   = 1'b1;
          end else if (tick) begin
            cd_d = cd_q - 8'd1;
          end
        end
        ST_SELF_CLEAN: begin
          if (expire) begin
            st_d   = ST_STANDBY;
            cd_d   = '0;
            done_d = 1'b1;
          end else if (tick) begin
            cd_d = cd_q - 8'd1;
          end
        end
        default: st_d = ST_OFF;
      endcase
    end

    if (st_d == ST_OFF) begin
      cd_d   = '0;
      exit_d = 1'b0;
      hu_d   = 1'b0;
    end

    // Power-off is only armed once the key has been seen released after power-on.
    armed_d = (st_d != ST_OFF) && (armed_q || !power_btn);
    if (st_q == ST_OFF || long_off || !power_btn || !armed_q) lp_d = '0;
    else                                                        lp_d = lp_q + 1'b1;
  end

  always_comb begin
    state          = st_q;
    countdown      = cd_q;
    exiting        = exit_q;
    hurricane_used = hu_q;
    clean_done     = done_q;
  end

endmodule

// File: tb/tb_hood_mode_controller.sv
// tb/tb_hood_mode_controller.sv - scoreboard bench for hood_mode_controller against a time-based reference model
module tb_hood_mode_controller;

  localparam int TICK = 4, LP = 3, HUR = 5, EXS = 3, CLS = 6;
  localparam int S_OFF = 0, S_STBY = 1, S_MSEL = 2, S_FIRST = 3, S_SECOND = 4, S_THIRD = 5, S_CLEAN = 6;
  localparam int B_NONE = 0, B_L1 = 1, B_L2 = 2, B_L3 = 3, B_CLEAN = 4, B_MENU = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0, power_btn = 1'b0, menu_btn = 1'b0;
  logic lvl1_btn = 1'b0, lvl2_btn = 1'b0, lvl3_btn = 1'b0, clean_btn = 1'b0;
  logic [2:0] state;
  logic [7:0] countdown;
  logic exiting, hurricane_used, clean_done;

  always #5 clk = ~clk;

  hood_mode_controller #(
    .TICK_CYCLES(TICK), .LONG_PRESS_S(LP), .HURRICANE_S(HUR), .EXIT_S(EXS), .CLEAN_S(CLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .power_btn(power_btn), .menu_btn(menu_btn),
    .lvl1_btn(lvl1_btn), .lvl2_btn(lvl2_btn), .lvl3_btn(lvl3_btn), .clean_btn(clean_btn),
    .state(state), .countdown(countdown), .exiting(exiting),
    .hurricane_used(hurricane_used), .clean_done(clean_done)
  );

  typedef struct {
    int cyc;
    int st;
    int cd;
    bit ex;
    bit hu;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: timers are absolute deadlines measured from the load edge.
  int m_st, m_hold, m_load, m_dur, cyc;
  bit m_hu, m_ex, m_done, m_prev, m_armed;

  function automatic int model_cd();
    if (m_st == S_THIRD || m_st == S_CLEAN) return m_dur - (cyc - m_load) / TICK;
    return 0;
  endfunction

  task automatic model_edge(input bit r, input bit p, input bit m, input bit l1,
                            input bit l2, input bit l3, input bit c);
    bit rise, off;
    int b;
    cyc++;
    m_done = 1'b0;
    if (!r) begin
      m_st = S_OFF; m_hu = 0; m_ex = 0; m_prev = 0; m_armed = 0; m_hold = 0; m_dur = 0; m_load = cyc;
      return;
    end
    rise = p && !m_prev;
    m_prev = p;
    if (m_st == S_OFF) begin
      if (rise) begin m_st = S_STBY; m_armed = 0; m_hold = 0; end
      return;
    end
    off = 1'b0;
    if (!p) begin m_armed = 1; m_hold = 0; end
    else if (m_armed) begin m_hold++; off = (m_hold == LP * TICK); end
    if (off) begin
      m_st = S_OFF; m_hu = 0; m_ex = 0; m_armed = 0; m_hold = 0;
    end else if ((m_st == S_THIRD || m_st == S_CLEAN) && (cyc - m_load == m_dur * TICK)) begin
      if (m_st == S_CLEAN) begin m_st = S_STBY; m_done = 1; end
      else if (m_ex) begin m_st = S_STBY; m_ex = 0; end
      else m_st = S_SECOND;
    end else begin
      b = l3 ? B_L3 : l2 ? B_L2 : l1 ? B_L1 : c ? B_CLEAN : m ? B_MENU : B_NONE;
      if (m_st == S_STBY) begin
        if (b == B_MENU) m_st = S_MSEL;
      end else if (m_st == S_MSEL || m_st == S_FIRST || m_st == S_SECOND) begin
        if (b == B_L3) begin
          if (!m_hu) begin m_st = S_THIRD; m_hu = 1; m_load = cyc; m_dur = HUR; end
        end else if (b == B_L2) m_st = S_SECOND;
        else if (b == B_L1) m_st = S_FIRST;
        else if (b == B_CLEAN) begin
          if (m_st == S_MSEL) begin m_st = S_CLEAN; m_load = cyc; m_dur = CLS; end
        end else if (b == B_MENU) m_st = S_STBY;
      end else if (m_st == S_THIRD) begin
        if (b == B_MENU && !m_ex) begin m_ex = 1; m_load = cyc; m_dur = EXS; end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Called at a negedge; applies inputs for the coming posedge and returns at the next negedge.
  task automatic drive(input bit r, input bit p, input bit m, input bit l1,
                       input bit l2, input bit l3, input bit c);
    exp_t e;
    rst_n = r; power_btn = p; menu_btn = m;
    lvl1_btn = l1; lvl2_btn = l2; lvl3_btn = l3; clean_btn = c;
    model_edge(r, p, m, l1, l2, l3, c);
    e.cyc = cyc; e.st = m_st; e.cd = model_cd(); e.ex = m_ex; e.hu = m_hu; e.done = m_done;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic pulse(input int which, input bit p);
    drive(1, p, which == B_MENU, which == B_L1, which == B_L2, which == B_L3, which == B_CLEAN);
  endtask

  task automatic idle(input int n, input bit p);
    for (int i = 0; i < n; i++) drive(1, p, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_now(input string name, input int st, input int cd);
    check({name, ".state"}, int'(state), st);
    check({name, ".countdown"}, int'(countdown), cd);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb.state", int'(state), e.st);
        check("sb.countdown", int'(countdown), e.cd);
        check("sb.exiting", int'(exiting), int'(e.ex));
        check("sb.hurricane_used", int'(hurricane_used), int'(e.hu));
        check("sb.clean_done", int'(clean_done), int'(e.done));
      end
    end
  end

  initial begin : stimulus
    int hold_left;
    bit p;
    cyc = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
    expect_now("reset", S_OFF, 0);
    check("reset.hurricane_used", int'(hurricane_used), 0);

    // Power on, menu, level 2, then a long press powers off.
    pulse(B_NONE, 1);  expect_now("power_on", S_STBY, 0);
    pulse(B_NONE, 0);
    pulse(B_MENU, 0);  expect_now("menu", S_MSEL, 0);
    pulse(B_L2, 0);    expect_now("lvl2", S_SECOND, 0);
    idle(11, 1);       expect_now("hold11", S_SECOND, 0);
    idle(1, 1);        expect_now("hold12_off", S_OFF, 0);
    idle(1, 0);

    // Hurricane run, auto-drop to second level, lvl3 then refused.
    pulse(B_NONE, 1); pulse(B_NONE, 0); pulse(B_MENU, 0);
    pulse(B_L3, 0);    expect_now("third_entry", S_THIRD, HUR);
    check("third.hurricane_used", int'(hurricane_used), 1);
    idle(19, 0);       expect_now("third_last_sec", S_THIRD, 1);
    idle(1, 0);        expect_now("third_expire", S_SECOND, 0);
    pulse(B_L3, 0);    expect_now("lvl3_refused", S_SECOND, 0);

    // Exit countdown from THIRD.
    idle(12, 1); idle(1, 0);
    pulse(B_NONE, 1); pulse(B_NONE, 0); pulse(B_MENU, 0); pulse(B_L3, 0);
    idle(4, 0);        expect_now("third_cd4", S_THIRD, 4);
    pulse(B_MENU, 0);  expect_now("exit_start", S_THIRD, EXS);
    check("exit.exiting", int'(exiting), 1);
    idle(11, 0);       expect_now("exit_last", S_THIRD, 1);
    idle(1, 0);        expect_now("exit_done", S_STBY, 0);
    check("exit_done.exiting", int'(exiting), 0);

    // Self-clean run and done pulse.
    pulse(B_MENU, 0);
    pulse(B_CLEAN, 0); expect_now("clean_entry", S_CLEAN, CLS);
    idle(23, 0);       expect_now("clean_last", S_CLEAN, 1);
    idle(1, 0);        expect_now("clean_end", S_STBY, 0);
    check("clean_done.pulse", int'(clean_done), 1);
    idle(1, 0);
    check("clean_done.cleared", int'(clean_done), 0);

    // Held through power-on never powers off until released once.
    idle(12, 1); idle(1, 0);
    idle(20, 1);       expect_now("held_power_on", S_STBY, 0);
    idle(1, 0);
    idle(12, 1);       expect_now("rehold_off", S_OFF, 0);
    check("rehold.hurricane_used", int'(hurricane_used), 0);
    idle(1, 0);

    // Reset in the middle of a self-clean countdown.
    pulse(B_NONE, 1); pulse(B_NONE, 0); pulse(B_MENU, 0); pulse(B_CLEAN, 0);
    idle(12, 0);       expect_now("clean_cd3", S_CLEAN, 3);
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_now("mid_reset", S_OFF, 0);
    check("mid_reset.clean_done", int'(clean_done), 0);

    // Randomised traffic checked by the scoreboard.
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left > 0) begin
        p = 1; hold_left--;
      end else begin
        p = 0;
        if ($urandom_range(0, 29) == 0) hold_left = int'($urandom_range(1, 16));
      end
      drive($urandom_range(0, 599) != 0, p,
            $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 11) == 0);
    end

    @(posedge clk); #2;
    check("sb.drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
